// File: rtl/aes_block_scheduler.sv
// Block scheduler between the AES input side, the round engine and the byte-serial output.
// Buffers one plaintext block, runs the engine under a watchdog, and releases ciphertext when the output is idle.
module aes_block_scheduler #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              pt_valid,
    input  logic [DATA_W-1:0] pt_in,
    output logic              input_ready,
    output logic              engine_start,
    output logic [DATA_W-1:0] engine_text,
    input  logic              engine_done,
    input  logic [DATA_W-1:0] engine_ct,
    output logic              done_out,
    output logic [DATA_W-1:0] ct_out,
    input  logic              output_read,
    output logic              busy,
    output logic [CNT_W-1:0]  block_count,
    output logic [2:0]        err_flags
);

    localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

    state_t              state;
    state_t              state_next;
    logic                pend_valid;
    logic [DATA_W-1:0]   pt_hold;
    logic [DATA_W-1:0]   ct_hold;
    logic                out_busy;
    logic [WDOG_W-1:0]   wdog;
    logic [WDOG_W-1:0]   wdog_inc;
    logic                timeout_hit;

    // The watchdog saturates; the timeout fires on the RUN cycle in which it would reach TIMEOUT.
    assign wdog_inc    = (wdog == {WDOG_W{1'b1}}) ? wdog : wdog + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (wdog_inc == WDOG_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (pend_valid) state_next = START;
            START: state_next = RUN;
            RUN: begin
                if (engine_done) begin
                    state_next = HOLD;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            HOLD:  if (!out_busy) state_next = pend_valid ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        engine_start = (state == START);
        engine_text  = (state == START) ? pt_hold : '0;
        done_out     = (state == HOLD) && !out_busy;
        ct_out       = ((state == HOLD) && !out_busy) ? ct_hold : '0;
    end

    // Pending buffer, engine capture, output handshake and sticky error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst_) begin
            pend_valid  <= 1'b0;
            pt_hold     <= '0;
            ct_hold     <= '0;
            out_busy    <= 1'b0;
            wdog        <= '0;
            block_count <= '0;
            err_flags   <= 3'b000;
        end else begin
            if (pt_valid && !pend_valid) begin
                pt_hold    <= pt_in;
                pend_valid <= 1'b1;
            end else if (state == START) begin
                pend_valid <= 1'b0;
            end
            if (pt_valid && pend_valid) begin
                err_flags[1] <= 1'b1;
            end

            wdog <= (state == RUN) ? wdog_inc : '0;
            if ((state == RUN) && engine_done) begin
                ct_hold <= engine_ct;
            end
            if ((state == RUN) && !engine_done && timeout_hit) begin
                err_flags[0] <= 1'b1;
            end
            if (engine_done && (state != RUN)) begin
                err_flags[2] <= 1'b1;
            end

            // done_out needs out_busy=0, so it can never coincide with a legal output_read.
            if (done_out) begin
                out_busy    <= 1'b1;
                block_count <= block_count + 1'b1;
            end else if (output_read) begin
                out_busy <= 1'b0;
            end
            if (output_read && !out_busy) begin
                err_flags[2] <= 1'b1;
            end
        end
    end

    assign input_ready = !pend_valid;
    assign busy        = (state != IDLE) || pend_valid || out_busy;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Directed bench for aes_block_scheduler: a vector table of full blocks plus
// hand-written sequences for latency, back-pressure, overrun, timeout and reset.
module tb_aes_block_scheduler;

    localparam int DW = 128;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_;
    logic          pt_valid;
    logic [DW-1:0] pt_in;
    logic          input_ready;
    logic          engine_start;
    logic [DW-1:0] engine_text;
    logic          engine_done;
    logic [DW-1:0] engine_ct;
    logic          done_out;
    logic [DW-1:0] ct_out;
    logic          output_read;
    logic          busy;
    logic [CW-1:0] block_count;
    logic [2:0]    err_flags;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [DW-1:0] pt;
        logic [DW-1:0] ct;
        int            lat;
        logic [CW-1:0] exp_count;
    } vec_t;

    vec_t vecs [3];

    aes_block_scheduler #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_(rst_), .pt_valid(pt_valid), .pt_in(pt_in),
        .input_ready(input_ready), .engine_start(engine_start), .engine_text(engine_text),
        .engine_done(engine_done), .engine_ct(engine_ct), .done_out(done_out),
        .ct_out(ct_out), .output_read(output_read), .busy(busy),
        .block_count(block_count), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses pt_valid and returns in the cycle engine_start is seen.
    task automatic applyStimulus(input logic [DW-1:0] pt);
        bit seen;
        seen     = 1'b0;
        pt_valid = 1'b1;
        pt_in    = pt;
        step();
        pt_valid = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (engine_start) seen = 1'b1;
            else step();
        end
        checkOutput("start_seen", seen, 1);
        if (seen) checkOutput("engine_text", engine_text, pt);
    endtask

    // From the engine_start cycle, answers on RUN cycle 'lat'; returns one cycle later.
    task automatic finishEngine(input int lat, input logic [DW-1:0] ct);
        repeat (lat) step();
        engine_done = 1'b1;
        engine_ct   = ct;
        step();
        engine_done = 1'b0;
    endtask

    task automatic readOut();
        output_read = 1'b1;
        step();
        output_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{pt: 128'h0123456789abcdef_fedcba9876543210, ct: 128'h3925841d02dc09fb_dc118597196a0b32, lat: 1, exp_count: 16'd2};
        vecs[1] = '{pt: 128'hffffffffffffffff_ffffffffffffffff, ct: 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, lat: 4, exp_count: 16'd3};
        vecs[2] = '{pt: 128'h00000000_00000000_00000000_00000001, ct: 128'hdeadbeef_cafef00d_12345678_9abcdef0, lat: 8, exp_count: 16'd4};

        rst_ = 1'b1; pt_valid = 1'b0; pt_in = '0; engine_done = 1'b0;
        engine_ct = '0; output_read = 1'b0;
        step(); step();
        rst_ = 1'b0;
        checkOutput("rst_input_ready", input_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err_flags, 0);
        checkOutput("rst_count", block_count, 0);
        checkOutput("rst_engine_start", engine_start, 0);
        checkOutput("rst_done_out", done_out, 0);

        // Exact latency: pt_valid at N, engine_start at N+2, input_ready back at N+3.
        pt_valid = 1'b1;
        pt_in    = 128'h00112233_44556677_8899aabb_ccddeeff;
        step();
        pt_valid = 1'b0;
        checkOutput("n1_input_ready", input_ready, 0);
        checkOutput("n1_engine_start", engine_start, 0);
        step();
        checkOutput("n2_engine_start", engine_start, 1);
        checkOutput("n2_engine_text", engine_text, 128'h00112233_44556677_8899aabb_ccddeeff);
        step();
        checkOutput("n3_input_ready", input_ready, 1);
        checkOutput("n3_engine_start", engine_start, 0);
        engine_done = 1'b1;
        engine_ct   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        step();
        engine_done = 1'b0;
        checkOutput("m1_done_out", done_out, 1);
        checkOutput("m1_ct_out", ct_out, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);
        checkOutput("m1_count", block_count, 0);
        step();
        checkOutput("m2_done_out", done_out, 0);
        checkOutput("m2_count", block_count, 1);
        checkOutput("m2_busy", busy, 1);
        readOut();
        checkOutput("read_busy", busy, 0);

        for (int v = 0; v < 3; v++) begin
            applyStimulus(vecs[v].pt);
            finishEngine(vecs[v].lat, vecs[v].ct);
            checkOutput($sformatf("vec%0d_done_out", v), done_out, 1);
            checkOutput($sformatf("vec%0d_ct_out", v), ct_out, vecs[v].ct);
            step();
            checkOutput($sformatf("vec%0d_count", v), block_count, vecs[v].exp_count);
            checkOutput($sformatf("vec%0d_err", v), err_flags, 3'b000);
            readOut();
        end

        // Overrun: a second pt_valid while the first block is pending is dropped.
        pt_valid = 1'b1;
        pt_in    = 128'h11111111_11111111_11111111_11111111;
        step();
        pt_in    = 128'h22222222_22222222_22222222_22222222;
        step();
        pt_valid = 1'b0;
        checkOutput("ovr_err", err_flags, 3'b010);
        checkOutput("ovr_engine_start", engine_start, 1);
        checkOutput("ovr_engine_text", engine_text, 128'h11111111_11111111_11111111_11111111);
        finishEngine(2, 128'h33333333_33333333_33333333_33333333);
        checkOutput("ovr_done_out", done_out, 1);
        checkOutput("ovr_ct_out", ct_out, 128'h33333333_33333333_33333333_33333333);
        step();
        checkOutput("ovr_count", block_count, 5);
        readOut();

        // Stray output_read while the output is idle.
        readOut();
        checkOutput("proto_err", err_flags, 3'b110);
        checkOutput("proto_busy", busy, 0);

        // Back-pressure: second ciphertext waits for output_read, released one cycle later.
        applyStimulus(128'haaaa0000_aaaa0000_aaaa0000_aaaa0000);
        finishEngine(2, 128'hc0c0c0c0_c0c0c0c0_c0c0c0c0_c0c0c0c0);
        checkOutput("bp_a_done_out", done_out, 1);
        step();
        applyStimulus(128'hbbbb0000_bbbb0000_bbbb0000_bbbb0000);
        finishEngine(1, 128'hd1d1d1d1_d1d1d1d1_d1d1d1d1_d1d1d1d1);
        checkOutput("bp_hold1_done_out", done_out, 0);
        step();
        checkOutput("bp_hold2_done_out", done_out, 0);
        checkOutput("bp_hold_count", block_count, 6);
        output_read = 1'b1;
        checkOutput("bp_t_done_out", done_out, 0);
        step();
        output_read = 1'b0;
        checkOutput("bp_t1_done_out", done_out, 1);
        checkOutput("bp_t1_ct_out", ct_out, 128'hd1d1d1d1_d1d1d1d1_d1d1d1d1_d1d1d1d1);
        step();
        checkOutput("bp_count", block_count, 7);
        readOut();

        // Watchdog: no engine_done for TIMEOUT RUN cycles.
        applyStimulus(128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa);
        repeat (TO) step();
        checkOutput("to_pre_err", err_flags, 3'b110);
        checkOutput("to_pre_busy", busy, 1);
        step();
        checkOutput("to_err", err_flags, 3'b111);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_count", block_count, 7);
        checkOutput("to_done_out", done_out, 0);

        // Reset while a block waits in HOLD behind a busy output.
        applyStimulus(128'h01010101_01010101_01010101_01010101);
        finishEngine(1, 128'h02020202_02020202_02020202_02020202);
        step();
        applyStimulus(128'h03030303_03030303_03030303_03030303);
        finishEngine(1, 128'h04040404_04040404_04040404_04040404);
        checkOutput("rs_pre_done_out", done_out, 0);
        checkOutput("rs_pre_count", block_count, 8);
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;
        checkOutput("rs_engine_start", engine_start, 0);
        checkOutput("rs_engine_text", engine_text, 0);
        checkOutput("rs_done_out", done_out, 0);
        checkOutput("rs_ct_out", ct_out, 0);
        checkOutput("rs_input_ready", input_ready, 1);
        checkOutput("rs_busy", busy, 0);
        checkOutput("rs_err", err_flags, 0);
        checkOutput("rs_count", block_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
